// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the spiking-network datapath blocks.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_UPDATE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < n) begin
            x = x * 2;
            r++;
        end
        return r;
    endfunction

    // Wide enough that summing every synapse at full weight cannot wrap.
    function automatic int acc_width(input int weight_w, input int num_syn);
        return weight_w + clog2(num_syn);
    endfunction

    // Synapse k occupies weights[k*weight_w +: weight_w] of the flattened bus.
    function automatic int weight_lsb(input int k, input int weight_w);
        return k * weight_w;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational membrane update: leak, integrate, clamp to V_MAX, threshold test.
module lif_update #(
    parameter int V_W        = 12,
    parameter int ACC_W      = 10,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [V_W-1:0]   v,
    input  logic [ACC_W-1:0] acc,
    input  logic             refractory,
    output logic [V_W-1:0]   v_next,
    output logic             fire
);

    localparam int SUM_W = ((V_W > ACC_W) ? V_W : ACC_W) + 1;
    localparam logic [SUM_W-1:0] V_MAX_EXT = {{(SUM_W-V_W){1'b0}}, {V_W{1'b1}}};
    localparam logic [V_W-1:0]   THR       = V_W'(THRESHOLD);

    function automatic logic [V_W-1:0] saturate(input logic [SUM_W-1:0] x);
        if (x > V_MAX_EXT) begin
            return {V_W{1'b1}};
        end
        return x[V_W-1:0];
    endfunction

    logic [SUM_W-1:0] v_ext;
    logic [SUM_W-1:0] sum;

    // v - (v >> s) never goes negative, so only the upper clamp is needed.
    assign v_ext  = SUM_W'(v);
    assign sum    = v_ext - (v_ext >> LEAK_SHIFT) + SUM_W'(acc);
    assign v_next = saturate(sum);
    assign fire   = !refractory && (v_next >= THR);

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: serial weighted spike sum, then one update cycle.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int NUM_SYNAPSES  = 100,
    parameter int WIDTH_P       = 8,
    parameter int V_W           = 12,
    parameter int THRESHOLD     = 200,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_i,
    input  logic [NUM_SYNAPSES-1:0]         spikes_i,
    input  logic                            step_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            spike_o,
    output logic [V_W-1:0]                  membrane_o
);

    localparam int ACC_W = acc_width(WIDTH_P, NUM_SYNAPSES);
    localparam int IDX_W = (clog2(NUM_SYNAPSES) > 0) ? clog2(NUM_SYNAPSES) : 1;
    localparam int REF_W = (clog2(REFRACT_STEPS + 1) > 0) ? clog2(REFRACT_STEPS + 1) : 1;

    state_t                  state;
    logic [NUM_SYNAPSES-1:0] snap;
    logic [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]        idx;
    logic [REF_W-1:0]        refract;
    logic [V_W-1:0]          v;

    logic [WIDTH_P-1:0]      w_cur;
    logic [V_W-1:0]          v_next;
    logic                    fire;
    logic                    refractory;
    logic                    last_syn;

    assign w_cur      = weights_i[weight_lsb(int'(idx), WIDTH_P) +: WIDTH_P];
    assign refractory = (refract != '0);
    assign last_syn   = (idx == IDX_W'(NUM_SYNAPSES - 1));
    assign busy_o     = (state != ST_IDLE);
    assign membrane_o = v;

    lif_update #(
        .V_W       (V_W),
        .ACC_W     (ACC_W),
        .THRESHOLD (THRESHOLD),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_update (
        .v         (v),
        .acc       (acc),
        .refractory(refractory),
        .v_next    (v_next),
        .fire      (fire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            snap    <= '0;
            acc     <= '0;
            idx     <= '0;
            refract <= '0;
            v       <= '0;
            done_o  <= 1'b0;
            spike_o <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            spike_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (step_i) begin
                        acc <= '0;
                        // A refractory step skips accumulation and only leaks.
                        if (refractory) begin
                            state <= ST_UPDATE;
                        end else begin
                            snap  <= spikes_i;
                            idx   <= '0;
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (snap[idx]) begin
                        acc <= acc + ACC_W'(w_cur);
                    end
                    if (last_syn) begin
                        idx   <= '0;
                        state <= ST_UPDATE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_UPDATE: begin
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                    if (fire) begin
                        spike_o <= 1'b1;
                        v       <= '0;
                        refract <= REF_W'(REFRACT_STEPS);
                    end else begin
                        v <= v_next;
                        if (refractory) begin
                            refract <= refract - REF_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: two instances (thresholds 200 and 4095) against a timestep-level model.
module tb_lif_neuron;

    localparam int N  = 4;
    localparam int WP = 8;
    localparam int VW = 12;
    localparam int LS = 3;
    localparam int RS = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*WP-1:0] weights;
    logic [N-1:0]    spikes;
    logic            step;
    logic            busy [2];
    logic            done [2];
    logic            spk  [2];
    logic [VW-1:0]   mem  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_neuron #(.NUM_SYNAPSES(N), .WIDTH_P(WP), .V_W(VW), .THRESHOLD(200),
                 .LEAK_SHIFT(LS), .REFRACT_STEPS(RS)) u_a (
        .clk_i(clk), .rst_i(rst), .weights_i(weights), .spikes_i(spikes), .step_i(step),
        .busy_o(busy[0]), .done_o(done[0]), .spike_o(spk[0]), .membrane_o(mem[0]));

    lif_neuron #(.NUM_SYNAPSES(N), .WIDTH_P(WP), .V_W(VW), .THRESHOLD(4095),
                 .LEAK_SHIFT(LS), .REFRACT_STEPS(RS)) u_b (
        .clk_i(clk), .rst_i(rst), .weights_i(weights), .spikes_i(spikes), .step_i(step),
        .busy_o(busy[1]), .done_o(done[1]), .spike_o(spk[1]), .membrane_o(mem[1]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Timestep-level model: a step occupies a fixed number of cycles, after which the
    // neuron equation is applied once.
    int thr [2] = '{200, 4095};
    int mv [2], mref [2], mcnt [2], macc [2];
    bit e_done [2], e_spk [2];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    mv[i] = 0; mref[i] = 0; mcnt[i] = 0; macc[i] = 0;
                    e_done[i] = 0; e_spk[i] = 0;
                end else begin
                    e_done[i] = 0;
                    e_spk[i]  = 0;
                    if (mcnt[i] == 0) begin
                        if (step) begin
                            macc[i] = 0;
                            if (mref[i] == 0) begin
                                for (int k = 0; k < N; k++)
                                    if (spikes[k]) macc[i] += int'(weights[k*WP +: WP]);
                                mcnt[i] = N + 1;
                            end else begin
                                mcnt[i] = 1;
                            end
                        end
                    end else begin
                        mcnt[i]--;
                        if (mcnt[i] == 0) begin
                            int vn;
                            vn = mv[i] - (mv[i] / 8) + macc[i];
                            if (vn > 4095) vn = 4095;
                            e_done[i] = 1;
                            if (mref[i] == 0 && vn >= thr[i]) begin
                                e_spk[i] = 1;
                                mv[i]    = 0;
                                mref[i]  = RS;
                            end else begin
                                mv[i] = vn;
                                if (mref[i] > 0) mref[i]--;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("busy%0d", i),  int'(busy[i]), int'(mcnt[i] > 0));
                    chk($sformatf("done%0d", i),  int'(done[i]), int'(e_done[i]));
                    chk($sformatf("spike%0d", i), int'(spk[i]),  int'(e_spk[i]));
                    chk($sformatf("mem%0d", i),   int'(mem[i]),  mv[i]);
                end
            end
        end
    end

    int r_lat [2];
    int r_spk [2];
    int r_busy;

    task automatic set_in(input int w, input logic [N-1:0] s);
        for (int k = 0; k < N; k++) weights[k*WP +: WP] = WP'(w);
        spikes = s;
    endtask

    // One-cycle step strobe, then wait (bounded) until both instances are idle again.
    task automatic do_step();
        bit idle;
        idle = 0;
        r_lat = '{-1, -1};
        r_spk = '{0, 0};
        r_busy = 0;
        @(negedge clk);
        step = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) step = 1'b0;
            if (busy[0]) r_busy++;
            for (int j = 0; j < 2; j++) begin
                if (done[j]) begin
                    r_lat[j] = i;
                    r_spk[j] = int'(spk[j]);
                end
            end
            if (!busy[0] && !busy[1]) begin
                idle = 1;
                break;
            end
        end
        chk("step_timeout", int'(idle), 1);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_b [6] = '{1020, 1913, 2694, 3378, 3976, 0};
    int ndone;
    int last;

    initial begin
        step = 1'b0;
        set_in(10, 4'b0101);
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(busy[0]), 0);
        chk("rst_done",  int'(done[0]), 0);
        chk("rst_spike", int'(spk[0]),  0);
        chk("rst_mem",   int'(mem[0]),  0);
        rst = 1'b0;

        do_step();
        chk("t1_lat",   r_lat[0], 6);
        chk("t1_mem",   int'(mem[0]), 20);
        chk("t1_spike", r_spk[0], 0);

        do_step();
        chk("t2_mem",   int'(mem[0]), 38);
        chk("t2_spike", r_spk[0], 0);
        chk("t2_busy",  r_busy, 5);

        set_in(100, 4'b1111);
        do_step();
        chk("t3_spike", r_spk[0], 1);
        chk("t3_mem",   int'(mem[0]), 0);
        for (int s = 0; s < 2; s++) begin
            do_step();
            chk("t3_ref_lat",   r_lat[0], 2);
            chk("t3_ref_mem",   int'(mem[0]), 0);
            chk("t3_ref_spike", r_spk[0], 0);
        end
        do_step();
        chk("t3_respike", r_spk[0], 1);

        pulse_rst();
        set_in(255, 4'b1111);
        for (int s = 0; s < 6; s++) begin
            do_step();
            chk($sformatf("t4_mem_s%0d", s + 1), int'(mem[1]), exp_b[s]);
            chk($sformatf("t4_spk_s%0d", s + 1), r_spk[1], (s == 5) ? 1 : 0);
        end

        pulse_rst();
        set_in(10, 4'b0101);
        do_step();
        chk("t5_pre_mem", int'(mem[0]), 20);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5_busy%0d", i),  int'(busy[i]), 0);
            chk($sformatf("t5_done%0d", i),  int'(done[i]), 0);
            chk($sformatf("t5_spike%0d", i), int'(spk[i]),  0);
            chk($sformatf("t5_mem%0d", i),   int'(mem[i]),  0);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        do_step();
        chk("t5_mem", int'(mem[0]), 20);

        ndone = 0;
        last  = 0;
        @(negedge clk);
        step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done[0]) begin
                ndone++;
                if (last > 0) chk("t6_gap", i - last, 6);
                last = i;
            end
        end
        step = 1'b0;
        chk("t6_held_dones", ndone, 3);
        repeat (10) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("t6_total_dones", ndone, 4);

        ndone = 0;
        @(negedge clk);
        step = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
            step = (i == 2 || i == 4);
        end
        chk("t6_busy_ignored", ndone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
